lsu: RTL
========

Name: lsu

Overview:
- Per-thread load/store unit. It sits directly upstream of the shared memory controller and drives one consumer read port and one consumer write port of that controller.
- It turns a decoded LDR/STR instruction into a single-word read or write transaction, waits for the controller's valid/ready handshake to finish, and holds the loaded value for the core's register update stage.
- One instance per thread per core.

Parameters:
- ADDR_BITS, 8, memory address width; must match the controller's ADDR_BITS.
- DATA_BITS, 16, memory data and register width.
- STALL_BITS, 8, width of the saturating per-request stall counter.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- enable  input  1  thread is active; when 0 the LSU never leaves IDLE
- core_state  input  3  core pipeline stage, encoded per core_pkg
- decoded_mem_read_enable  input  1  current instruction is LDR
- decoded_mem_write_enable  input  1  current instruction is STR
- rs  input  DATA_BITS  address operand; low ADDR_BITS bits are used
- rt  input  DATA_BITS  store data operand
- mem_read_valid  output  1  read request to the controller
- mem_read_address  output  ADDR_BITS  read address
- mem_read_ready  input  1  controller read-complete flag
- mem_read_data  input  DATA_BITS  controller read data
- mem_write_valid  output  1  write request to the controller
- mem_write_address  output  ADDR_BITS  write address
- mem_write_data  output  DATA_BITS  write data
- mem_write_ready  input  1  controller write-complete flag
- lsu_state  output  2  IDLE=00, REQUESTING=01, WAITING=10, DONE=11
- lsu_out  output  DATA_BITS  last loaded word
- stall_cycles  output  STALL_BITS  cycles spent in WAITING for the last request

Behaviour:
- Reset (reset=0, asynchronous): every output is 0 and lsu_state=IDLE. Reset asserted mid-transaction drops valid immediately and discards the transaction.
- IDLE:
  - Transition condition: enable=1, core_state==REQUEST, (read_en or write_en), and both mem_read_ready and mem_write_ready are 0.
  - On that edge: go to REQUESTING; capture address=rs[ADDR_BITS-1:0], data=rt, operation; clear stall_cycles.
  - If read_en and write_en are both 1, the operation is a read; write_en is ignored.
  - If either ready is still high, the LSU stays in IDLE. This covers the controller's relaying phase left over from the previous request.
- REQUESTING:
  - Next edge: assert mem_read_valid (read) or mem_write_valid (write) and go to WAITING. Address and data outputs are stable from this edge.
  - Read and write valid are never both 1.
- WAITING:
  - Valid is held and stall_cycles increments each cycle, saturating at all-ones.
  - On an edge where the matching ready=1: clear valid, latch lsu_out<=mem_read_data (read only), go to DONE.
  - The non-matching ready is ignored.
- DONE:
  - Hold lsu_out. On core_state==UPDATE, go to IDLE on that edge.
  - The controller keeps ready high until it sees valid low. The LSU never re-raises valid while ready=1, so it completes the controller's four-phase handshake.
- Latency: REQUEST seen at edge t gives valid high after edge t+1. Ready seen at edge t+k gives valid low and lsu_out updated after t+k.
- enable falling mid-transaction has no effect; the transaction completes normally.
- lsu_out changes only on read completion; a store leaves it unchanged.
- Address/data outputs keep their last value after valid drops.

Decomposition:
- core_pkg holds:
  - core_state encodings: FETCH=000, DECODE=001, REQUEST=011, WAIT=100, EXECUTE=101, UPDATE=110, DONE=111.
  - lsu_state_t enum.
  - Default ADDR_BITS and DATA_BITS.
- No sub-module; the saturating stall counter is inline.

Test Plan:
- Load: rs=0x0042, read_en, REQUEST; controller returns 0xBEEF with ready 3 cycles after valid → mem_read_address=0x42, valid cleared on ready, lsu_out=0xBEEF, stall_cycles=3, state DONE until UPDATE.
- Store: rs=0x0010, rt=0x1234, write_en → mem_write_valid=1 with address 0x10 and data 0x1234, mem_read_valid stays 0, lsu_out unchanged, DONE reached after write_ready.
- Back-to-back with ready held: ready still high when a second REQUEST arrives → LSU stays IDLE until ready=0, then issues; no valid pulse overlaps ready.
- Both enables set, rs=0x0005 → read only at 0x05, write valid never asserted.
- Reset mid-WAITING: drive reset=0 between edges → valid and all outputs 0 immediately (asynchronously), state IDLE, next request issues cleanly.
- Stall saturation: STALL_BITS=4, ready withheld 20 cycles → stall_cycles=15, and the transaction still completes correctly.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core-level encodings: pipeline stage codes, LSU state enum and default widths.
package core_pkg;

  localparam int unsigned ADDR_BITS_DEF  = 8;
  localparam int unsigned DATA_BITS_DEF  = 16;
  localparam int unsigned STALL_BITS_DEF = 8;

  // Core pipeline stage as broadcast to every thread
  typedef enum logic [2:0] {
    CS_FETCH   = 3'b000,
    CS_DECODE  = 3'b001,
    CS_REQUEST = 3'b011,
    CS_WAIT    = 3'b100,
    CS_EXECUTE = 3'b101,
    CS_UPDATE  = 3'b110,
    CS_DONE    = 3'b111
  } core_state_e;

  // Load/store unit transaction state
  typedef enum logic [1:0] {
    LSU_IDLE       = 2'b00,
    LSU_REQUESTING = 2'b01,
    LSU_WAITING    = 2'b10,
    LSU_DONE       = 2'b11
  } lsu_state_t;

endpackage

// File: rtl/lsu.sv
// Per-thread load/store unit: issues one single-word read or write to the
// memory controller per LDR/STR and holds the loaded word for register update.
module lsu
  import core_pkg::*;
#(
  parameter int unsigned ADDR_BITS  = ADDR_BITS_DEF,
  parameter int unsigned DATA_BITS  = DATA_BITS_DEF,
  parameter int unsigned STALL_BITS = STALL_BITS_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [2:0]            core_state,
  input  logic                  decoded_mem_read_enable,
  input  logic                  decoded_mem_write_enable,
  input  logic [DATA_BITS-1:0]  rs,
  input  logic [DATA_BITS-1:0]  rt,
  output logic                  mem_read_valid,
  output logic [ADDR_BITS-1:0]  mem_read_address,
  input  logic                  mem_read_ready,
  input  logic [DATA_BITS-1:0]  mem_read_data,
  output logic                  mem_write_valid,
  output logic [ADDR_BITS-1:0]  mem_write_address,
  output logic [DATA_BITS-1:0]  mem_write_data,
  input  logic                  mem_write_ready,
  output logic [1:0]            lsu_state,
  output logic [DATA_BITS-1:0]  lsu_out,
  output logic [STALL_BITS-1:0] stall_cycles
);

  lsu_state_t state_q, state_d;

  logic                  op_read_q,  op_read_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  wr_valid_q, wr_valid_d;
  logic [ADDR_BITS-1:0]  rd_addr_q,  rd_addr_d;
  logic [ADDR_BITS-1:0]  wr_addr_q,  wr_addr_d;
  logic [DATA_BITS-1:0]  wr_data_q,  wr_data_d;
  logic [DATA_BITS-1:0]  out_q,      out_d;
  logic [STALL_BITS-1:0] stall_q,    stall_d;

  logic start_c;
  logic done_c;
  logic unused_rs_hi_c;

  // Only the low address bits of rs reach the controller
  assign unused_rs_hi_c = ^rs[DATA_BITS-1:ADDR_BITS];

  // Accept a new request only once the controller has dropped both readies,
  // so a lingering ready from the previous transaction is never mistaken
  // for completion of this one.
  assign start_c = enable
                 && (core_state == CS_REQUEST)
                 && (decoded_mem_read_enable || decoded_mem_write_enable)
                 && !mem_read_ready
                 && !mem_write_ready;

  // Only the ready matching the captured operation completes the request
  assign done_c = op_read_q ? mem_read_ready : mem_write_ready;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= LSU_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LSU_IDLE:       if (start_c) state_d = LSU_REQUESTING;
      LSU_REQUESTING: state_d = LSU_WAITING;
      LSU_WAITING:    if (done_c) state_d = LSU_DONE;
      LSU_DONE:       if (core_state == CS_UPDATE) state_d = LSU_IDLE;
      default:        state_d = LSU_IDLE;
    endcase
  end

  // Next values of the registered outputs and captured operation
  always_comb begin
    op_read_d  = op_read_q;
    rd_valid_d = rd_valid_q;
    wr_valid_d = wr_valid_q;
    rd_addr_d  = rd_addr_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    out_d      = out_q;
    stall_d    = stall_q;
    unique case (state_q)
      LSU_IDLE: begin
        if (start_c) begin
          // A simultaneous LDR/STR decode is treated as a load
          op_read_d = decoded_mem_read_enable;
          stall_d   = '0;
          if (decoded_mem_read_enable) begin
            rd_addr_d = rs[ADDR_BITS-1:0];
          end else begin
            wr_addr_d = rs[ADDR_BITS-1:0];
            wr_data_d = rt;
          end
        end
      end
      LSU_REQUESTING: begin
        rd_valid_d = op_read_q;
        wr_valid_d = !op_read_q;
      end
      LSU_WAITING: begin
        if (stall_q != {STALL_BITS{1'b1}}) begin
          stall_d = stall_q + STALL_BITS'(1);
        end
        if (done_c) begin
          rd_valid_d = 1'b0;
          wr_valid_d = 1'b0;
          if (op_read_q) begin
            out_d = mem_read_data;
          end
        end
      end
      LSU_DONE: begin
        rd_valid_d = 1'b0;
        wr_valid_d = 1'b0;
      end
      default: begin
        rd_valid_d = 1'b0;
        wr_valid_d = 1'b0;
      end
    endcase
  end

  // Output and operation registers; reset discards any transaction in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_read_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      wr_valid_q <= 1'b0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      out_q      <= '0;
      stall_q    <= '0;
    end else begin
      op_read_q  <= op_read_d;
      rd_valid_q <= rd_valid_d;
      wr_valid_q <= wr_valid_d;
      rd_addr_q  <= rd_addr_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      out_q      <= out_d;
      stall_q    <= stall_d;
    end
  end

  assign mem_read_valid    = rd_valid_q;
  assign mem_read_address  = rd_addr_q;
  assign mem_write_valid   = wr_valid_q;
  assign mem_write_address = wr_addr_q;
  assign mem_write_data    = wr_data_q;
  assign lsu_state         = state_q;
  assign lsu_out           = out_q;
  assign stall_cycles      = stall_q;

endmodule
